// File: rtl/vpe_icache_pkg.sv
// Shared types and helpers for the VPE instruction cache.
// Optional parity protection is enabled by defining ICACHE_PARITY_EN.
package vpe_icache_pkg;

  localparam int unsigned DEF_DATA_W = 12;
  localparam int unsigned DEF_ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } seq_state_t;

  // Even parity: the returned bit makes the XOR of word plus parity equal to zero.
  function automatic logic even_par(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/vpe_icache_skid.sv
// Two-entry valid/ready skid buffer; slot0 is always the head so output data
// stays stable while the consumer stalls.
module vpe_icache_skid #(
  parameter int unsigned W = 13
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic [1:0]   count
);

  logic [W-1:0] slot0, slot1;
  logic [1:0]   cnt;
  logic         pop;

  assign pop       = out_ready && (cnt != 2'd0);
  assign out_valid = (cnt != 2'd0);
  assign out_data  = slot0;
  assign count     = cnt;

  // The producer never pushes into a full buffer without a simultaneous pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0 <= '0;
      slot1 <= '0;
      cnt   <= 2'd0;
    end else begin
      case (cnt)
        2'd0: begin
          if (in_valid) begin
            slot0 <= in_data;
            cnt   <= 2'd1;
          end
        end
        2'd1: begin
          if (in_valid && pop) begin
            slot0 <= in_data;
          end else if (in_valid) begin
            slot1 <= in_data;
            cnt   <= 2'd2;
          end else if (pop) begin
            cnt <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            slot0 <= slot1;
            if (in_valid) slot1 <= in_data;
            else          cnt   <= 2'd1;
          end
        end
        default: cnt <= 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/vpe_icache_seq.sv
// VPE instruction cache: register-file storage, random read port and a fetch
// sequencer streaming a program slice. Parity option: ICACHE_PARITY_EN.
module vpe_icache_seq
  import vpe_icache_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_valid,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_valid,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_loop,
  input  logic              i_stop,
  output logic              o_ins_valid,
  output logic [DATA_W-1:0] o_ins_data,
  output logic              o_ins_last,
  input  logic              i_ins_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_par_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
`ifdef ICACHE_PARITY_EN
  localparam int unsigned MEM_W = DATA_W + 1;
`else
  localparam int unsigned MEM_W = DATA_W;
`endif

  logic [MEM_W-1:0] mem [DEPTH];
  logic [MEM_W-1:0] wr_word;

`ifdef ICACHE_PARITY_EN
  assign wr_word = {even_par(64'(i_wr_data)), i_wr_data};
`else
  assign wr_word = i_wr_data;
`endif

  always_ff @(posedge clk) begin
    if (i_wr_valid) mem[i_wr_addr] <= wr_word;
  end

  // Random read port, read-first against a same-cycle write.
  logic [MEM_W-1:0] rd_word;
  logic             rd_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_word    <= '0;
    end else begin
      rd_valid_q <= i_rd_valid;
      if (i_rd_valid) rd_word <= mem[i_rd_addr];
    end
  end

  assign o_rd_valid = rd_valid_q;
  assign o_rd_data  = rd_word[DATA_W-1:0];

  // Fetch sequencer
  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, base_q, base_d, iss_addr;
  logic [LEN_W-1:0]  rem_q, rem_d, len_q, len_d;
  logic              loop_q, loop_d;
  logic              inflight_q, inflight_last_q;
  logic [MEM_W-1:0]  fetch_word;
  logic              zero_done_q, zero_done_d;
  logic              issue, iss_last, drain_done;
  logic              pop, credit_ok;
  logic [1:0]        skid_cnt;
  logic [2:0]        occ;

  assign pop = o_ins_valid && i_ins_ready;
  assign occ = 3'(skid_cnt) + 3'(inflight_q);
  // Counting the word leaving this cycle keeps one issue per cycle under constant ready.
  assign credit_ok = (occ < 3'd2) || (pop && (occ == 3'd2));

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    base_d      = base_q;
    len_d       = len_q;
    loop_d      = loop_q;
    issue       = 1'b0;
    iss_addr    = addr_q;
    iss_last    = (rem_q == LEN_W'(1));
    zero_done_d = 1'b0;
    drain_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          if (i_len == '0) begin
            zero_done_d = 1'b1;
          end else begin
            // First word is issued in the start cycle to meet the two-cycle latency.
            issue    = 1'b1;
            iss_addr = i_base;
            iss_last = (i_len == LEN_W'(1));
            base_d   = i_base;
            len_d    = i_len;
            loop_d   = i_loop;
            state_d  = (iss_last && !i_loop) ? DRAIN : FETCH;
            if (iss_last) begin
              addr_d = i_base;
              rem_d  = i_len;
            end else begin
              addr_d = i_base + ADDR_W'(1);
              rem_d  = i_len - LEN_W'(1);
            end
          end
        end
      end
      FETCH: begin
        if (i_stop) begin
          state_d = DRAIN;
        end else if (credit_ok) begin
          issue = 1'b1;
          if (iss_last) begin
            if (loop_q) begin
              addr_d = base_q;
              rem_d  = len_q;
            end else begin
              state_d = DRAIN;
            end
          end else begin
            addr_d = addr_q + ADDR_W'(1);
            rem_d  = rem_q - LEN_W'(1);
          end
        end
      end
      DRAIN: begin
        if ((skid_cnt == 2'd0) && !inflight_q) begin
          state_d    = IDLE;
          drain_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      rem_q           <= '0;
      base_q          <= '0;
      len_q           <= '0;
      loop_q          <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      fetch_word      <= '0;
      zero_done_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      rem_q           <= rem_d;
      base_q          <= base_d;
      len_q           <= len_d;
      loop_q          <= loop_d;
      inflight_q      <= issue;
      inflight_last_q <= issue && iss_last;
      zero_done_q     <= zero_done_d;
      if (issue) fetch_word <= mem[iss_addr];
    end
  end

  assign o_busy = (state_q != IDLE);
  assign o_done = drain_done || zero_done_q;

  vpe_icache_skid #(
    .W(DATA_W + 1)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (inflight_q),
    .in_data  ({inflight_last_q, fetch_word[DATA_W-1:0]}),
    .out_valid(o_ins_valid),
    .out_data ({o_ins_last, o_ins_data}),
    .out_ready(i_ins_ready),
    .count    (skid_cnt)
  );

`ifdef ICACHE_PARITY_EN
  logic par_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err_q <= 1'b0;
    end else if ((rd_valid_q && (^rd_word)) || (inflight_q && (^fetch_word))) begin
      par_err_q <= 1'b1;
    end
  end

  assign o_par_err = par_err_q;
`else
  assign o_par_err = 1'b0;
`endif

endmodule

// File: tb/tb_vpe_icache_seq.sv
// Scoreboard bench for vpe_icache_seq: stimulus pushes expected words, a
// negedge monitor pops and compares whenever the DUT presents data.
module tb_vpe_icache_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_wr_valid;
  logic [7:0]  i_wr_addr;
  logic [11:0] i_wr_data;
  logic        i_rd_valid;
  logic [7:0]  i_rd_addr;
  logic        o_rd_valid;
  logic [11:0] o_rd_data;
  logic        i_start;
  logic [7:0]  i_base;
  logic [8:0]  i_len;
  logic        i_loop;
  logic        i_stop;
  logic        o_ins_valid;
  logic [11:0] o_ins_data;
  logic        o_ins_last;
  logic        i_ins_ready;
  logic        o_busy;
  logic        o_done;
  logic        o_par_err;

  int checks   = 0;
  int failures = 0;

  logic [11:0] rd_q[$];
  logic [12:0] ins_q[$];
  logic [11:0] model_mem [256];

  logic        prev_stall = 1'b0;
  logic [12:0] prev_word  = '0;

  always #5 clk = ~clk;

  vpe_icache_seq #(
    .DATA_W(12),
    .ADDR_W(8),
    .LEN_W (9)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wr_valid (i_wr_valid),
    .i_wr_addr  (i_wr_addr),
    .i_wr_data  (i_wr_data),
    .i_rd_valid (i_rd_valid),
    .i_rd_addr  (i_rd_addr),
    .o_rd_valid (o_rd_valid),
    .o_rd_data  (o_rd_data),
    .i_start    (i_start),
    .i_base     (i_base),
    .i_len      (i_len),
    .i_loop     (i_loop),
    .i_stop     (i_stop),
    .o_ins_valid(o_ins_valid),
    .o_ins_data (o_ins_data),
    .o_ins_last (o_ins_last),
    .i_ins_ready(i_ins_ready),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_par_err  (o_par_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every presented word against the queued expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("ins_hold", {19'd0, o_ins_valid, o_ins_last, o_ins_data}, {19'd0, 1'b1, prev_word});
      if (o_rd_valid) begin
        if (rd_q.size() == 0) chk("rd_unexpected", 32'(o_rd_data), 32'hFFFF_FFFF);
        else                  chk("rd_data", 32'(o_rd_data), 32'(rd_q.pop_front()));
      end
      if (o_ins_valid && i_ins_ready) begin
        if (ins_q.size() == 0) chk("ins_unexpected", {19'd0, o_ins_last, o_ins_data}, 32'hFFFF_FFFF);
        else                   chk("ins_word", {19'd0, o_ins_last, o_ins_data}, 32'(ins_q.pop_front()));
      end
      prev_stall = o_ins_valid && !i_ins_ready;
      prev_word  = {o_ins_last, o_ins_data};
    end
  end

  task automatic wr(input logic [7:0] a, input logic [11:0] d);
    i_wr_valid   = 1'b1;
    i_wr_addr    = a;
    i_wr_data    = d;
    model_mem[a] = d;
    tick();
    i_wr_valid   = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a);
    i_rd_valid = 1'b1;
    i_rd_addr  = a;
    rd_q.push_back(model_mem[a]);
    tick();
    i_rd_valid = 1'b0;
  endtask

  task automatic expect_slice(input logic [7:0] base, input int unsigned len);
    logic [7:0] a;
    for (int unsigned k = 0; k < len; k++) begin
      a = base + 8'(k);
      ins_q.push_back({(k == len - 1), model_mem[a]});
    end
  endtask

  task automatic start_seq(input logic [7:0] base, input logic [8:0] len, input logic loop);
    i_start = 1'b1;
    i_base  = base;
    i_len   = len;
    i_loop  = loop;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input logic toggle_ready);
    logic seen;
    seen = 1'b0;
    for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
      if (toggle_ready) i_ins_ready = ~i_ins_ready;
      tick();
      if (o_done) seen = 1'b1;
    end
    chk(name, 32'(seen), 32'd1);
    i_ins_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic quiet;
    rst_n = 1'b0;
    i_wr_valid = 1'b0; i_wr_addr = '0; i_wr_data = '0;
    i_rd_valid = 1'b0; i_rd_addr = '0;
    i_start = 1'b0; i_base = '0; i_len = '0; i_loop = 1'b0; i_stop = 1'b0;
    i_ins_ready = 1'b1;
    for (int i = 0; i < 256; i++) model_mem[i] = '0;
    #12;
    chk("reset_outputs", {26'd0, o_rd_valid, o_ins_valid, o_ins_last, o_busy, o_done, o_par_err}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: writes then random reads, including write-then-read next cycle
    for (int i = 0; i < 11; i++) wr(8'(i), 12'(i + 1));
    rd(8'd10);
    for (int i = 0; i < 10; i++) rd(8'(i));
    wr(8'd20, 12'h333);
    i_wr_valid = 1'b1; i_wr_addr = 8'd20; i_wr_data = 12'h555;
    i_rd_valid = 1'b1; i_rd_addr = 8'd20;
    rd_q.push_back(12'h333);
    tick();
    model_mem[20] = 12'h555;
    i_wr_valid = 1'b0; i_rd_valid = 1'b0;
    rd(8'd20);
    for (int i = 250; i < 256; i++) wr(8'(i), 12'hA00 | 12'(i));
    tick();

    // 2: base 0 len 10, constant ready, exact timing
    i_ins_ready = 1'b1;
    expect_slice(8'd0, 10);
    start_seq(8'd0, 9'd10, 1'b0);
    chk("first_valid_c1", 32'(o_ins_valid), 32'd0);
    tick();
    chk("first_valid_c2", 32'(o_ins_valid), 32'd1);
    quiet = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (!o_ins_valid) quiet = 1'b0;
    end
    chk("back_to_back", 32'(quiet), 32'd1);
    tick();
    chk("done_after_drain", {30'd0, o_done, o_busy}, 32'd3);
    tick();
    chk("idle_after_done", {30'd0, o_done, o_busy}, 32'd0);

    // 3: ready toggling
    expect_slice(8'd0, 10);
    start_seq(8'd0, 9'd10, 1'b0);
    wait_done("done_toggle", 1'b1);
    tick();

    // 4: wrap past top of memory; start while busy is ignored
    expect_slice(8'd250, 10);
    start_seq(8'd250, 9'd10, 1'b0);
    tick(); tick();
    start_seq(8'd100, 9'd5, 1'b0);
    wait_done("done_wrap", 1'b0);
    tick();

    // 5: loop base 4 len 3, start+stop together, stop in cycle 8
    for (int p = 0; p < 8; p++)
      ins_q.push_back({(p % 3 == 2), model_mem[4 + (p % 3)]});
    i_stop = 1'b1;
    start_seq(8'd4, 9'd3, 1'b1);
    i_stop = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
    wait_done("done_loop_stop", 1'b0);
    tick();

    // 6: zero length, then async reset mid-fetch
    start_seq(8'd0, 9'd0, 1'b0);
    chk("zero_len_done", {29'd0, o_done, o_busy, o_ins_valid}, 32'd4);
    tick();
    chk("zero_len_after", {29'd0, o_done, o_busy, o_ins_valid}, 32'd0);
    i_ins_ready = 1'b0;
    start_seq(8'd0, 9'd10, 1'b0);
    tick(); tick();
    chk("stalled_busy", {30'd0, o_busy, o_ins_valid}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_mid_fetch", {17'd0, o_rd_valid, o_ins_valid, o_ins_last, o_busy, o_done, o_ins_data}, 32'd0);
    tick();
    rst_n = 1'b1;
    i_ins_ready = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (o_done || o_busy || o_ins_valid) quiet = 1'b0;
    end
    chk("no_done_after_reset", 32'(quiet), 32'd1);

    chk("rd_queue_empty", 32'(rd_q.size()), 32'd0);
    chk("ins_queue_empty", 32'(ins_q.size()), 32'd0);
    chk("par_err_clear", 32'(o_par_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
